// File: rtl/packet_inject.sv
// Source-side packetizer: turns one request plus a stream of payload words into a HEAD/BODY/TAIL or SINGLE flit sequence under credit flow control.
// Optional build macro INJECT_TIMESTAMP_EN: cmp carries an injection timestamp instead of the hop count.
module packet_inject #(
  parameter int cur_x        = 0,
  parameter int cur_y        = 0,
  parameter int cur_z        = 0,
  parameter int BUF_DEPTH    = 4,
  parameter int MAX_LEN      = 8,
  parameter int LENW         = 4,
  parameter int FLIT_SIZE    = 32,
  parameter int HEADER_LEN   = 2,
  parameter int VC_CLASS_POS = 29,
  parameter int DST_ZPOS     = 27,
  parameter int DST_YPOS     = 25,
  parameter int DST_XPOS     = 23,
  parameter int CMP_POS      = 19,
  parameter int CMP_LEN      = 4,
  parameter int XW           = 2,
  parameter int YW           = 2,
  parameter int ZW           = 2,
  parameter int XSIZE        = 4,
  parameter int YSIZE        = 4,
  parameter int ZSIZE        = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [XW-1:0]                    req_dst_x,
  input  logic [YW-1:0]                    req_dst_y,
  input  logic [ZW-1:0]                    req_dst_z,
  input  logic [LENW-1:0]                  req_len,
  input  logic                             data_valid,
  output logic                             data_ready,
  input  logic [FLIT_SIZE-HEADER_LEN-1:0]  data_in,
  output logic [FLIT_SIZE-1:0]             flit_out,
  output logic                             flit_valid_out,
  input  logic                             credit_in,
  output logic                             busy,
  output logic                             credit_err,
  output logic                             dbg_state_o,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   dbg_credits_o
);

  localparam int CW = $clog2(BUF_DEPTH+1);
  localparam logic [HEADER_LEN-1:0] HEAD_T   = HEADER_LEN'(0);
  localparam logic [HEADER_LEN-1:0] BODY_T   = HEADER_LEN'(1);
  localparam logic [HEADER_LEN-1:0] TAIL_T   = HEADER_LEN'(2);
  localparam logic [HEADER_LEN-1:0] SINGLE_T = HEADER_LEN'(3);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                 state_q;
  logic                   req_ready_q, busy_q, err_q, first_q, single_q, flit_valid_q;
  logic [LENW-1:0]        remaining_q, len_d;
  logic [CW-1:0]          credits_q;
  logic [XW-1:0]          dst_x_q;
  logic [YW-1:0]          dst_y_q;
  logic [ZW-1:0]          dst_z_q;
  logic [CMP_LEN-1:0]     cmp_q, cmp_d;
  logic [FLIT_SIZE-1:0]   flit_q, flit_d;
  logic [HEADER_LEN-1:0]  flit_type_d;
  logic                   accept;

  // Handshake: a payload beat transfers in any cycle where data_valid and data_ready are both high;
  // data_ready is only offered in SEND with at least one credit, so it is never held without a word present.
  assign accept     = (state_q == SEND) && data_valid && (credits_q != '0);
  assign data_ready = accept;

  assign req_ready      = req_ready_q;
  assign busy           = busy_q;
  assign credit_err     = err_q;
  assign flit_out       = flit_q;
  assign flit_valid_out = flit_valid_q;
  assign dbg_state_o    = state_q;
  assign dbg_credits_o  = credits_q;

  always_comb begin
    len_d = req_len;
    if (req_len == '0) len_d = LENW'(1);
    else if (req_len > LENW'(MAX_LEN)) len_d = LENW'(MAX_LEN);
  end

`ifdef INJECT_TIMESTAMP_EN
  logic [CMP_LEN-1:0] ts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + CMP_LEN'(1);
  end

  assign cmp_d = ts_q;
`else
  // Shortest distance along one torus ring: going the other way round may be closer.
  function automatic logic [CMP_LEN-1:0] axis_hops(input int dst, input int cur, input int size);
    int d;
    d = (dst > cur) ? dst - cur : cur - dst;
    if (size - d < d) d = size - d;
    return CMP_LEN'(d);
  endfunction

  assign cmp_d = axis_hops(int'(req_dst_x), cur_x, XSIZE)
               + axis_hops(int'(req_dst_y), cur_y, YSIZE)
               + axis_hops(int'(req_dst_z), cur_z, ZSIZE);
`endif

  always_comb begin
    flit_type_d = BODY_T;
    if (single_q)                        flit_type_d = SINGLE_T;
    else if (first_q)                    flit_type_d = HEAD_T;
    else if (remaining_q == LENW'(1))    flit_type_d = TAIL_T;
    flit_d = '0;
    if (single_q || first_q) begin
      flit_d[FLIT_SIZE-1 -: HEADER_LEN] = flit_type_d;
      flit_d[VC_CLASS_POS]              = 1'b0;
      flit_d[DST_ZPOS +: ZW]            = dst_z_q;
      flit_d[DST_YPOS +: YW]            = dst_y_q;
      flit_d[DST_XPOS +: XW]            = dst_x_q;
      flit_d[CMP_POS +: CMP_LEN]        = cmp_q;
      flit_d[CMP_POS-1:0]               = data_in[CMP_POS-1:0];
    end else begin
      flit_d = {flit_type_d, data_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      first_q      <= 1'b0;
      single_q     <= 1'b0;
      remaining_q  <= '0;
      credits_q    <= CW'(BUF_DEPTH);
      dst_x_q      <= '0;
      dst_y_q      <= '0;
      dst_z_q      <= '0;
      cmp_q        <= '0;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
    end else begin
      flit_valid_q <= accept;
      if (accept) flit_q <= flit_d;

      // A beat and a returned credit in the same cycle cancel out.
      if (accept && !credit_in) begin
        credits_q <= credits_q - CW'(1);
      end else if (!accept && credit_in) begin
        if (credits_q == CW'(BUF_DEPTH)) err_q <= 1'b1;
        else                             credits_q <= credits_q + CW'(1);
      end

      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q     <= SEND;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            first_q     <= 1'b1;
            single_q    <= (len_d == LENW'(1));
            remaining_q <= len_d;
            dst_x_q     <= req_dst_x;
            dst_y_q     <= req_dst_y;
            dst_z_q     <= req_dst_z;
            cmp_q       <= cmp_d;
          end
        end
        SEND: begin
          if (accept) begin
            first_q     <= 1'b0;
            remaining_q <= remaining_q - LENW'(1);
            if (remaining_q == LENW'(1)) begin
              state_q     <= IDLE;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_inject.sv
// Self-checking bench for packet_inject on a 4x4x4 torus at node (1,1,1) with a 4-slot injection buffer.
module tb_packet_inject;

  localparam logic [1:0] T_HEAD = 2'd0, T_BODY = 2'd1, T_TAIL = 2'd2, T_SINGLE = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_dst_x = '0, req_dst_y = '0, req_dst_z = '0;
  logic [3:0]  req_len = '0;
  logic        data_valid = 1'b0, data_ready;
  logic [29:0] data_in = '0;
  logic [31:0] flit_out;
  logic        flit_valid_out;
  logic        credit_in = 1'b0;
  logic        busy, credit_err;
  logic        dbg_state_o;
  logic [2:0]  dbg_credits_o;

  logic [31:0] exp_q[$];
  logic [29:0] words [0:7];
  int errors = 0, checks = 0;
  int in_flight = 0, acc = 0, used = 0, cyc = 0;
  logic prev_acc = 1'b0;

  packet_inject #(.cur_x(1), .cur_y(1), .cur_z(1), .BUF_DEPTH(4), .MAX_LEN(8), .LENW(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst_x(req_dst_x), .req_dst_y(req_dst_y), .req_dst_z(req_dst_z), .req_len(req_len),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .flit_out(flit_out), .flit_valid_out(flit_valid_out),
    .credit_in(credit_in), .busy(busy), .credit_err(credit_err),
    .dbg_state_o(dbg_state_o), .dbg_credits_o(dbg_credits_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  // reference model: hop count on a 4-node ring per axis
  function automatic int hop(input int d, input int c);
    int a;
    a = (d > c) ? d - c : c - d;
    return (4 - a < a) ? 4 - a : a;
  endfunction

  // scoreboard
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && flit_valid_out) begin
      in_flight++;
      checks++;
      if (in_flight > 4) begin
        errors++;
        $display("FAIL credit_overflow got=%0d exp<=4", in_flight);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL flit_unexpected got=%h exp=none", flit_out);
      end else begin
        e = exp_q.pop_front();
        if (flit_out !== e) begin
          errors++;
          $display("FAIL flit_data got=%h exp=%h", flit_out, e);
        end
      end
    end
  end

  // driver tasks (all entered and left at posedge+1)
  task automatic send_req(input logic [1:0] x, input logic [1:0] y, input logic [1:0] z, input logic [3:0] len);
    int n, w;
    logic [3:0] cmp;
    logic [29:0] d;
    w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL req_ready_wait got=%0b exp=1", req_ready);
    end
`ifdef INJECT_TIMESTAMP_EN
    cmp = 4'(cyc % 16);
`else
    cmp = 4'(hop(int'(x), 1) + hop(int'(y), 1) + hop(int'(z), 1));
`endif
    n = (len == 0) ? 1 : int'(len);
    for (int i = 0; i < 8; i++) words[i] = 30'($urandom);
    for (int i = 0; i < n; i++) begin
      d = words[i];
      if (n == 1)          exp_q.push_back({T_SINGLE, 1'b0, z, y, x, cmp, d[18:0]});
      else if (i == 0)     exp_q.push_back({T_HEAD, 1'b0, z, y, x, cmp, d[18:0]});
      else if (i == n - 1) exp_q.push_back({T_TAIL, d});
      else                 exp_q.push_back({T_BODY, d});
    end
    req_valid = 1'b1; req_dst_x = x; req_dst_y = y; req_dst_z = z; req_len = len;
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc = 0;
    prev_acc = 1'b0;
  endtask

  // mode 0: no credits returned, 1: random valid/credits, 2: credit every cycle, 3: one credit in the first cycle
  task automatic run_beats(input int target, input int max_cyc, input int mode);
    int c;
    c = 0;
    while (acc < target && c < max_cyc) begin
      data_in = words[acc];
      data_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      credit_in = 1'b0;
      if (in_flight > 0 && (mode == 2 || (mode == 1 && $urandom_range(0, 1) == 1) || (mode == 3 && c == 0))) begin
        credit_in = 1'b1;
        in_flight--;
      end
      @(negedge clk);
      checks++;
      if (flit_valid_out !== prev_acc) begin
        errors++;
        $display("FAIL flit_latency got=%0b exp=%0b", flit_valid_out, prev_acc);
      end
      prev_acc = data_ready;
      if (data_ready) acc++;
      @(posedge clk); #1;
      c++;
    end
    used = c;
    data_valid = 1'b0;
    credit_in = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    @(negedge clk); @(posedge clk); #1;
    while (in_flight > 0 && c < 20) begin
      credit_in = 1'b1;
      in_flight--;
      @(posedge clk); #1;
      c++;
    end
    credit_in = 1'b0;
    prev_acc = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_pending got=%0d exp=0", exp_q.size());
    end
    checks++;
    if (dbg_credits_o !== 3'd4) begin
      errors++;
      $display("FAIL drain_credits got=%0d exp=4", dbg_credits_o);
    end
  endtask

  // scenarios
  task automatic test_reset();
    checks++; if (req_ready !== 1'b1)      begin errors++; $display("FAIL rst_req_ready got=%0b exp=1", req_ready); end
    checks++; if (data_ready !== 1'b0)     begin errors++; $display("FAIL rst_data_ready got=%0b exp=0", data_ready); end
    checks++; if (flit_valid_out !== 1'b0) begin errors++; $display("FAIL rst_flit_valid got=%0b exp=0", flit_valid_out); end
    checks++; if (flit_out !== 32'h0)      begin errors++; $display("FAIL rst_flit_out got=%h exp=0", flit_out); end
    checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if (credit_err !== 1'b0)     begin errors++; $display("FAIL rst_credit_err got=%0b exp=0", credit_err); end
    checks++; if (dbg_credits_o !== 3'd4)  begin errors++; $display("FAIL rst_credits got=%0d exp=4", dbg_credits_o); end
  endtask

  task automatic test_idle_ignore();
    data_valid = 1'b1;
    data_in = 30'($urandom);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (data_ready !== 1'b0) begin errors++; $display("FAIL idle_data_ready got=%0b exp=0", data_ready); end
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
  endtask

  task automatic test_basic();
    send_req(2'd3, 2'd0, 2'd1, 4'd3);
    run_beats(3, 10, 0);
    checks++;
    if (used !== 3) begin errors++; $display("FAIL basic_cycles got=%0d exp=3", used); end
    @(negedge clk);
    checks++;
    if (flit_valid_out !== 1'b1) begin errors++; $display("FAIL basic_tail_valid got=%0b exp=1", flit_valid_out); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL basic_req_ready got=%0b exp=1", req_ready); end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_single();
    send_req(2'd1, 2'd1, 2'd1, 4'd1);
    run_beats(1, 5, 0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got=%0b exp=0", busy); end
    checks++;
    if (flit_valid_out !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b exp=1", flit_valid_out); end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_stall();
    send_req(2'd2, 2'd3, 2'd0, 4'd6);
    run_beats(6, 8, 0);
    checks++;
    if (acc !== 4) begin errors++; $display("FAIL stall_count got=%0d exp=4", acc); end
    data_valid = 1'b1;
    data_in = words[acc];
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL stall_data_ready got=%0b exp=0", data_ready); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy got=%0b exp=1", busy); end
    @(posedge clk); #1;
    run_beats(6, 4, 3);
    checks++;
    if (acc !== 5) begin errors++; $display("FAIL stall_release got=%0d exp=5", acc); end
    run_beats(6, 40, 2);
    checks++;
    if (acc !== 6) begin errors++; $display("FAIL stall_finish got=%0d exp=6", acc); end
    drain();
  endtask

  task automatic test_random();
    int n;
    logic [3:0] len;
    for (int p = 0; p < 12; p++) begin
      len = 4'($urandom_range(0, 8));
      n = (len == 0) ? 1 : int'(len);
      send_req(2'($urandom), 2'($urandom), 2'($urandom), len);
      run_beats(n, 300, 1);
      checks++;
      if (acc !== n) begin errors++; $display("FAIL random_done got=%0d exp=%0d", acc, n); end
    end
    drain();
    checks++;
    if (credit_err !== 1'b0) begin errors++; $display("FAIL random_credit_err got=%0b exp=0", credit_err); end
  endtask

  task automatic test_back_to_back();
    send_req(2'd0, 2'd2, 2'd3, 4'd4);
    run_beats(2, 10, 2);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_req_ready_send got=%0b exp=0", req_ready); end
    req_valid = 1'b1; req_dst_x = 2'd3; req_dst_y = 2'd3; req_dst_z = 2'd3; req_len = 4'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    prev_acc = 1'b0;
    run_beats(4, 20, 2);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got=%0b%0b exp=10", req_ready, busy);
    end
    send_req(2'd2, 2'd2, 2'd2, 4'd2);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_busy got=%0b exp=1", busy); end
    run_beats(2, 20, 2);
    drain();
  endtask

  task automatic test_same_cycle();
    send_req(2'd1, 2'd3, 2'd2, 4'd5);
    run_beats(3, 5, 0);
    checks++;
    if (dbg_credits_o !== 3'd1) begin errors++; $display("FAIL same_setup_credits got=%0d exp=1", dbg_credits_o); end
    run_beats(5, 2, 3);
    checks++;
    if (acc !== 5) begin errors++; $display("FAIL same_no_stall got=%0d exp=5", acc); end
    checks++;
    if (dbg_credits_o !== 3'd0) begin errors++; $display("FAIL same_credits got=%0d exp=0", dbg_credits_o); end
    drain();
    checks++;
    if (credit_err !== 1'b0) begin errors++; $display("FAIL same_err_early got=%0b exp=0", credit_err); end
    credit_in = 1'b1;
    @(posedge clk); #1;
    credit_in = 1'b0;
    checks++;
    if (credit_err !== 1'b1) begin errors++; $display("FAIL credit_err_set got=%0b exp=1", credit_err); end
    checks++;
    if (dbg_credits_o !== 3'd4) begin errors++; $display("FAIL credit_saturate got=%0d exp=4", dbg_credits_o); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (credit_err !== 1'b1) begin errors++; $display("FAIL credit_err_sticky got=%0b exp=1", credit_err); end
  endtask

  task automatic test_reset_mid();
    send_req(2'd0, 2'd2, 2'd3, 4'd4);
    run_beats(1, 5, 0);
    @(negedge clk);
    checks++;
    if (flit_valid_out !== 1'b1) begin errors++; $display("FAIL mid_head_valid got=%0b exp=1", flit_valid_out); end
    #2 rst = 1'b1;
    #1;
    checks++; if (flit_valid_out !== 1'b0) begin errors++; $display("FAIL mid_flit_valid got=%0b exp=0", flit_valid_out); end
    checks++; if (dbg_credits_o !== 3'd4)  begin errors++; $display("FAIL mid_credits got=%0d exp=4", dbg_credits_o); end
    checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL mid_busy got=%0b exp=0", busy); end
    checks++; if (credit_err !== 1'b0)     begin errors++; $display("FAIL mid_credit_err got=%0b exp=0", credit_err); end
    exp_q.delete();
    in_flight = 0;
    prev_acc = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_req_ready got=%0b exp=1", req_ready); end
    @(posedge clk); #1;
    send_req(2'd3, 2'd3, 2'd0, 4'd2);
    run_beats(2, 10, 0);
    drain();
  endtask

`ifdef INJECT_TIMESTAMP_EN
  task automatic test_timestamp();
    int t0, w;
    t0 = cyc;
    send_req(2'd2, 2'd0, 2'd0, 4'd1);
    run_beats(1, 5, 0);
    w = 0;
    while (cyc < t0 + 7 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    send_req(2'd0, 2'd2, 2'd0, 4'd1);
    run_beats(1, 5, 0);
    drain();
  endtask
`endif

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_idle_ignore();
    test_basic();
    test_single();
    test_stall();
    test_random();
    test_back_to_back();
`ifdef INJECT_TIMESTAMP_EN
    test_timestamp();
`endif
    test_same_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
